wb_timer: RTL
=============

Name: wb_timer

Overview:
- RISC-V machine timer and software-interrupt device (CLINT-style) on the data Wishbone bus.
- Sits downstream of memory_wrapper as a secondary device slot, alongside main_memory.
- Holds 64-bit mtime, 64-bit mtimecmp and the msip bit.
- Drives timer_interrupt and software_interrupt into the core's interrupt inputs.

Parameters:
- CLK_DIV, 1: mtime increments once every CLK_DIV clk cycles. Legal range is 1..65535.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_cyc  in  1  Wishbone cycle
- wb_stb  in  1  Wishbone strobe
- wb_wr_en  in  1  1 = write, 0 = read
- wb_addr  in  32  byte address; only [4:2] decoded
- wb_wr_data  in  32  write data
- wb_wr_sel  in  4  byte-lane enables
- wb_ack  out  1  transfer acknowledge
- wb_stall  out  1  always 0
- wb_rd_data  out  32  read data, valid when wb_ack = 1
- timer_interrupt  out  1  mtime >= mtimecmp
- software_interrupt  out  1  msip bit

Behaviour:
- Reset values: mtime = 0, mtimecmp = MTIMECMP_RESET, msip = 0, div counter = 0, wb_ack = 0, wb_rd_data = 0, timer_interrupt = 0, software_interrupt = 0.
- Register map (wb_addr[4:2]):
  - 0 = mtime[31:0]
  - 1 = mtime[63:32]
  - 2 = mtimecmp[31:0]
  - 3 = mtimecmp[63:32]
  - 4 = msip (bit 0; bits 31:1 read 0)
  - 5–7 unmapped: read 0, writes ignored, still acked.
- Wishbone handshake (pipelined):
  - A request is accepted every cycle wb_cyc & wb_stb = 1. wb_stall is tied to 0.
  - wb_ack is registered and asserts exactly 1 cycle after acceptance.
  - Back-to-back requests produce back-to-back acks.
  - wb_rd_data is registered and captured in the accept cycle, so a read returns the pre-write/pre-increment value of that cycle.
  - If wb_cyc = 0, the next-cycle wb_ack is forced to 0 (aborted cycle, no ack).
  - wb_rd_data holds its last value when wb_ack = 0.
- Writes:
  - Byte-lane granular per wb_wr_sel; unselected bytes are unchanged.
  - Write with wb_wr_sel = 0 is acked with no effect.
- Prescaler: div counter counts 0..CLK_DIV-1. On terminal count, mtime <= mtime + 1 and the counter wraps to 0. When CLK_DIV = 1, mtime increments every cycle.
- mtime wraps from 2^64-1 to 0 with no flag.
- A bus write to either mtime half in the same cycle as a tick takes priority. The written half gets the bus data, the other half keeps its old value, and the increment is dropped for that cycle. The div counter is unaffected.
- Carry from the low word into the high word occurs within the same increment (full 64-bit add).
- timer_interrupt:
  - Registered: next = (mtime >= mtimecmp), unsigned 64-bit compare of the current register values. One cycle latency after a register change.
  - Level-sensitive; clears only by raising mtimecmp or lowering mtime.
- software_interrupt: registered copy of msip; asserts 1 cycle after the write ack cycle.
- Reset mid-transaction: all state returns to reset values immediately (async), the in-flight ack is dropped, and the master must retry.

Optional Feature:
WB_TIMER_SNAPSHOT_EN:
- Defined:
  - A read of mtime[31:0] (offset 0) latches mtime[63:32] into a 32-bit shadow register in the same cycle.
  - A read of offset 1 returns the shadow, giving an atomic 64-bit read order: lo then hi.
  - Shadow resets to 0. A write to offset 1 writes live mtime and does not modify the shadow.
- Undefined: offset 1 returns the live mtime[63:32]; no shadow register exists.

Test Plan:
- Reset, CLK_DIV = 1, run 10 cycles, read offset 0 → ack 1 cycle after stb; data equals 10 ± the fixed read latency (bench computes exactly); wb_stall = 0 throughout.
- Write mtime lo = 32'hFFFF_FFFE, hi = 0, CLK_DIV = 1 → after 2 ticks mtime = 64'h1_0000_0000; read hi = 1.
- Write mtimecmp = 64'd100, mtime = 64'd95 → timer_interrupt rises exactly 1 cycle after mtime reaches 100. Write mtimecmp hi = 1 → it falls 1 cycle later.
- Write offset 4 data 32'h1 sel 4'b0001 → software_interrupt = 1; write sel 4'b0000 data 0 → stays 1; write 0 sel 4'b0001 → 0; read offset 6 → 0, acked.
- CLK_DIV = 4: observe mtime increments every 4 cycles. Write mtime lo = 5 on a tick cycle → mtime = 5, then 6 after 4 more cycles.
- Snapshot (macro defined): mtime = 64'h0000_0001_FFFF_FFFF, read lo, let carry occur, read hi → hi = 1 (not 2). Without macro → hi = 2. Assert rst mid-read → no ack, all outputs 0.

Source files
------------

// File: rtl/wb_timer.sv
// wb_timer: CLINT-style machine timer (mtime/mtimecmp) and msip device on a pipelined Wishbone slave port.
// Latency: wb_ack/wb_rd_data one cycle after acceptance; interrupts registered, one cycle after a register change.
// Backpressure: none; wb_stall is tied low and one request is accepted every cycle wb_cyc & wb_stb is high.
// Optional: define WB_TIMER_SNAPSHOT_EN to latch mtime[63:32] on a low-word read for an atomic lo-then-hi read.
module wb_timer #(
  parameter int unsigned CLK_DIV        = 1,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_wr_en,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wr_data,
  input  logic [3:0]  wb_wr_sel,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic [31:0] wb_rd_data,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  // Terminal count of the prescaler; CLK_DIV is limited to 1..65535 so 16 bits suffice.
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        accept;
  logic        rd_req;
  logic        wr_req;
  logic [2:0]  reg_sel;
  logic        wr_time_lo;
  logic        wr_time_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_msip;
  logic        tick;
  logic [15:0] div_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [31:0] rd_mux;
  logic        unused_addr;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign accept   = wb_cyc & wb_stb;
  assign rd_req   = accept & ~wb_wr_en;
  // A write with no byte lanes enabled is acked but touches nothing, not even the tick.
  assign wr_req   = accept & wb_wr_en & (|wb_wr_sel);
  assign reg_sel  = wb_addr[4:2];
  assign wb_stall = 1'b0;

  assign wr_time_lo = wr_req & (reg_sel == 3'd0);
  assign wr_time_hi = wr_req & (reg_sel == 3'd1);
  assign wr_cmp_lo  = wr_req & (reg_sel == 3'd2);
  assign wr_cmp_hi  = wr_req & (reg_sel == 3'd3);
  assign wr_msip    = wr_req & (reg_sel == 3'd4) & wb_wr_sel[0];

  assign tick = (div_cnt == DIV_LAST);

  // Only [4:2] are decoded; the rest of the address is ignored.
  assign unused_addr = ^{wb_addr[31:5], wb_addr[1:0]};

`ifdef WB_TIMER_SNAPSHOT_EN
  logic [31:0] snap_hi;

  // Capture the high word alongside every low-word read so a following high read is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              snap_hi <= '0;
    else if (rd_req && reg_sel == 3'd0)   snap_hi <= mtime[63:32];
  end
`endif

  // Prescaler: free-running 0..CLK_DIV-1, never disturbed by bus writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end

  // mtime: a bus write to either half wins over the tick, and that tick's increment is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             mtime        <= '0;
    else if (wr_time_lo) mtime[31:0]  <= merge_bytes(mtime[31:0], wb_wr_data, wb_wr_sel);
    else if (wr_time_hi) mtime[63:32] <= merge_bytes(mtime[63:32], wb_wr_data, wb_wr_sel);
    else if (tick)       mtime        <= mtime + 64'd1;
  end

  // mtimecmp and msip are plain byte-writable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= MTIMECMP_RESET;
      msip     <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wb_wr_data, wb_wr_sel);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb_wr_data, wb_wr_sel);
      if (wr_msip)   msip            <= wb_wr_data[0];
    end
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      3'd0:    rd_mux = mtime[31:0];
`ifdef WB_TIMER_SNAPSHOT_EN
      3'd1:    rd_mux = snap_hi;
`else
      3'd1:    rd_mux = mtime[63:32];
`endif
      3'd2:    rd_mux = mtimecmp[31:0];
      3'd3:    rd_mux = mtimecmp[63:32];
      3'd4:    rd_mux = {31'd0, msip};
      default: rd_mux = '0;
    endcase
  end

  // Bus response: one ack per accepted request, data captured in the accept cycle and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack     <= 1'b0;
      wb_rd_data <= '0;
    end else begin
      wb_ack <= accept;
      if (accept) wb_rd_data <= rd_mux;
    end
  end

  // Interrupt lines are registered views of the compare and of msip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_interrupt    <= 1'b0;
      software_interrupt <= 1'b0;
    end else begin
      timer_interrupt    <= (mtime >= mtimecmp);
      software_interrupt <= msip;
    end
  end

endmodule
